// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes and master state encoding
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_mst_state_t;

endpackage

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding command to AXI4-Lite master bridge with timeout
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  axil_mst_state_t state;
  logic [31:0] addr_q;
  logic [15:0] tcnt;
  logic        aw_done, w_done;
  logic        aw_fire, w_fire;
  logic        busy, expire, phase_done, timeout_hit;

  // Address is held in one register; only the channel whose valid is up uses it.
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  // Gated by rst so the port reads 0 while reset is asserted even though state is IDLE.
  assign cmd_ready = (state == IDLE) && !rst;

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign busy    = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_RESP);
  // Expire on the cycle whose increment would bring the count to TIMEOUT.
  assign expire  = (17'(tcnt) + 17'd1) >= 17'(TIMEOUT);
  assign timeout_hit = busy && expire && !phase_done;

  // Decide whether the current state's handshake completes this cycle; it beats a timeout.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      WR_REQ:  phase_done = (aw_done || aw_fire) && (w_done || w_fire);
      WR_RESP: phase_done = bvalid && bready;
      RD_REQ:  phase_done = arvalid && arready;
      RD_RESP: phase_done = rvalid && rready;
      default: phase_done = 1'b0;
    endcase
  end

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      tcnt        <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (busy) tcnt <= tcnt + 16'd1;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata   <= cmd_wdata;
            wstrb   <= cmd_wstrb;
            tcnt    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (phase_done) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (phase_done) begin
            bready      <= 1'b0;
            rsp_resp    <= bresp;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RSP;
          end
        end
        RD_REQ: begin
          if (phase_done) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (phase_done) begin
            rready      <= 1'b0;
            rsp_rdata   <= rdata;
            rsp_resp    <= rresp;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Forced completion overrides whatever the busy state scheduled above.
      if (timeout_hit) begin
        awvalid     <= 1'b0;
        wvalid      <= 1'b0;
        bready      <= 1'b0;
        arvalid     <= 1'b0;
        rready      <= 1'b0;
        rsp_resp    <= RESP_SLVERR;
        rsp_rdata   <= '0;
        rsp_timeout <= 1'b1;
        rsp_valid   <= 1'b1;
        state       <= RSP;
      end
    end
  end

endmodule
